sprite_table_reader: RTL and testbench

SPRITE_TABLE_READER -- requirements
Module: sprite_table_reader

---
 rtl/sprite_pkg.sv | 54 +++++
 rtl/sprite_slot_match.sv | 18 +
 rtl/sprite_table_reader.sv | 209 ++++++++++++++++++++
 tb/tb_sprite_table_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite table reader: descriptor field layout,
// default geometry, the per-line slot record and the scan FSM encoding.
package sprite_pkg;

    localparam int DEF_NUM_ENTRIES = 8;
    localparam int DEF_NUM_SLOTS   = 4;
    localparam int DEF_SPRITE_SIZE = 32;

    localparam int IDX_W   = 3;
    localparam int COORD_W = 10;
    localparam int OFF_W   = 5;
    localparam int ROMA_W  = 16;

    // descriptor word: {en, rsvd, pos_x, pos_y, row, col}
    localparam int EN_BIT  = 31;
    localparam int RSVD_HI = 30;
    localparam int RSVD_LO = 26;
    localparam int PX_HI   = 25;
    localparam int PX_LO   = 16;
    localparam int PY_HI   = 15;
    localparam int PY_LO   = 6;
    localparam int ROW_HI  = 5;
    localparam int ROW_LO  = 3;
    localparam int COL_HI  = 2;
    localparam int COL_LO  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic                     valid;
        logic [IDX_W-1:0]         idx;
        logic [COORD_W-1:0]       pos_x;
        logic [ROW_HI-ROW_LO:0]   row;
        logic [COL_HI-COL_LO:0]   col;
        logic [OFF_W-1:0]         y_off;
    } slot_t;

    // base <= v < base+size, one extra bit so sprites near 1023 never wrap
    function automatic logic in_span(input logic [COORD_W-1:0] base,
                                     input logic [COORD_W-1:0] v,
                                     input int                 size);
        logic [COORD_W:0] b;
        logic [COORD_W:0] p;
        logic [COORD_W:0] lim;
        b   = {1'b0, base};
        p   = {1'b0, v};
        lim = b + (COORD_W+1)'(size);
        return (p >= b) && (p < lim);
    endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// One active sprite slot: horizontal coverage test and column offset into
// the sprite for the current pixel.
module sprite_slot_match
    import sprite_pkg::*;
#(
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE
) (
    input  logic               valid_i,
    input  logic [COORD_W-1:0] pos_x_i,
    input  logic [COORD_W-1:0] h_cnt_i,
    output logic               hit_o,
    output logic [OFF_W-1:0]   x_off_o
);

    assign hit_o   = valid_i && in_span(pos_x_i, h_cnt_i, SPRITE_SIZE);
    assign x_off_o = h_cnt_i[OFF_W-1:0] - pos_x_i[OFF_W-1:0];

endmodule

// File: rtl/sprite_table_reader.sv
// Sprite descriptor table with a per-scanline qualification scan feeding a
// double-buffered slot set, and a 2-stage per-pixel hit/ROM-address pipeline.
module sprite_table_reader
    import sprite_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [IDX_W-1:0]   addr,
    input  logic [31:0]        dina,
    input  logic               line_start,
    input  logic [COORD_W-1:0] next_line,
    input  logic [COORD_W-1:0] h_cnt,
    input  logic               de,
    output logic               pix_de,
    output logic               pix_hit,
    output logic [IDX_W-1:0]   pix_idx,
    output logic [ROMA_W-1:0]  rom_addr,
    output logic               scan_busy,
    output logic               overflow
);

    localparam int               CNT_W    = $clog2(NUM_SLOTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    logic [31:0] tbl_q [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
        end else if (we) begin
            tbl_q[addr] <= dina;
        end
    end

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [COORD_W-1:0] line_q, line_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        line_d  = line_q;
        case (state_q)
            ST_SCAN: begin
                if (ptr_q == LAST_IDX) state_d = ST_IDLE;
                else                   ptr_d   = ptr_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        // a new line always (re)starts the scan from entry 0
        if (line_start) begin
            state_d = ST_SCAN;
            ptr_d   = '0;
            line_d  = next_line;
        end
    end

    logic [31:0] ent;
    logic        unused_rsvd;
    logic        qual;
    slot_t       rec;

    assign ent         = tbl_q[ptr_q];
    assign unused_rsvd = ^ent[RSVD_HI:RSVD_LO];
    assign qual        = (state_q == ST_SCAN) && ent[EN_BIT] &&
                         in_span(ent[PY_HI:PY_LO], line_q, SPRITE_SIZE);

    always_comb begin
        rec.valid = 1'b1;
        rec.idx   = ptr_q;
        rec.pos_x = ent[PX_HI:PX_LO];
        rec.row   = ent[ROW_HI:ROW_LO];
        rec.col   = ent[COL_HI:COL_LO];
        rec.y_off = line_q[OFF_W-1:0] - ent[PY_LO+OFF_W-1:PY_LO];
    end

    slot_t [NUM_SLOTS-1:0] pend_q, pend_d, act_q, act_d;
    logic  [CNT_W-1:0]     pcnt_q, pcnt_d;
    logic                  povf_q, povf_d, ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            act_q  <= '0;
            pcnt_q <= '0;
            povf_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            pcnt_q <= pcnt_d;
            povf_q <= povf_d;
            ovf_q  <= ovf_d;
        end
    end

    // line_start wins over a visit in the same cycle: that visit is discarded
    // because the scan restarts at entry 0 anyway
    always_comb begin
        pend_d = pend_q;
        pcnt_d = pcnt_q;
        povf_d = povf_q;
        act_d  = act_q;
        ovf_d  = ovf_q;
        if (line_start) begin
            act_d  = pend_q;
            ovf_d  = povf_q;
            pend_d = '0;
            pcnt_d = '0;
            povf_d = 1'b0;
        end else if (qual) begin
            if (pcnt_q == CNT_W'(NUM_SLOTS)) begin
                povf_d = 1'b1;
            end else begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (pcnt_q == CNT_W'(s)) pend_d[s] = rec;
                end
                pcnt_d = pcnt_q + CNT_W'(1);
            end
        end
    end

    logic [NUM_SLOTS-1:0]            hit;
    logic [NUM_SLOTS-1:0][OFF_W-1:0] xoff;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sprite_slot_match #(
            .SPRITE_SIZE (SPRITE_SIZE)
        ) u_match (
            .valid_i (act_q[g].valid),
            .pos_x_i (act_q[g].pos_x),
            .h_cnt_i (h_cnt),
            .hit_o   (hit[g]),
            .x_off_o (xoff[g])
        );
    end

    logic             sel_hit;
    slot_t            sel_slot;
    logic [OFF_W-1:0] sel_xoff;
    logic             s1_take;

    // slots are filled in entry order, so the lowest hitting slot is the
    // lowest entry index
    always_comb begin
        sel_hit  = 1'b0;
        sel_slot = '0;
        sel_xoff = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (hit[s]) begin
                sel_hit  = 1'b1;
                sel_slot = act_q[s];
                sel_xoff = xoff[s];
            end
        end
    end

    assign s1_take = de && sel_hit;

    logic [1:0]        de_pipe_q;
    logic              s1_hit_q, pix_hit_q;
    logic [IDX_W-1:0]  s1_idx_q, pix_idx_q;
    logic [ROMA_W-1:0] s1_addr_q, rom_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            de_pipe_q  <= '0;
            s1_hit_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_addr_q  <= '0;
            pix_hit_q  <= 1'b0;
            pix_idx_q  <= '0;
            rom_addr_q <= '0;
        end else begin
            de_pipe_q  <= {de_pipe_q[0], de};
            s1_hit_q   <= s1_take;
            s1_idx_q   <= s1_take ? sel_slot.idx : '0;
            s1_addr_q  <= s1_take ? {sel_slot.row, sel_slot.y_off, sel_slot.col, sel_xoff} : '0;
            pix_hit_q  <= s1_hit_q;
            pix_idx_q  <= s1_idx_q;
            rom_addr_q <= s1_addr_q;
        end
    end

    assign pix_de    = de_pipe_q[1];
    assign pix_hit   = pix_hit_q;
    assign pix_idx   = pix_idx_q;
    assign rom_addr  = rom_addr_q;
    assign scan_busy = (state_q != ST_IDLE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sprite_table_reader.sv
// Directed + randomized bench for sprite_table_reader against a line-level
// model of the descriptor table, pending/active slot sets and pixel lookup.
module tb_sprite_table_reader;

    localparam int SZ = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] dina = '0;
    logic        line_start = 1'b0;
    logic [9:0]  next_line = '0;
    logic [9:0]  h_cnt = '0;
    logic        de = 1'b0;
    logic        pix_de, pix_hit, scan_busy, overflow;
    logic [2:0]  pix_idx;
    logic [15:0] rom_addr;

    always #5 clk = ~clk;

    sprite_table_reader dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .dina       (dina),
        .line_start (line_start),
        .next_line  (next_line),
        .h_cnt      (h_cnt),
        .de         (de),
        .pix_de     (pix_de),
        .pix_hit    (pix_hit),
        .pix_idx    (pix_idx),
        .rom_addr   (rom_addr),
        .scan_busy  (scan_busy),
        .overflow   (overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          de;
        bit          hit;
        int          idx;
        logic [15:0] ra;
    } pexp_t;

    pexp_t       pq[$];
    logic [31:0] desc[8];
    logic [31:0] pend_snap[8];
    logic [31:0] act_snap[8];
    int          pend_idx[$];
    int          act_idx[$];
    int          pend_line, act_line;
    bit          pend_ovf, act_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit en, input int x, input int y,
                                       input int row, input int col);
        return {en, 5'($urandom), 10'(x), 10'(y), 3'(row), 3'(col)};
    endfunction

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            desc[i] = '0; pend_snap[i] = '0; act_snap[i] = '0;
        end
        pend_idx.delete(); act_idx.delete();
        pend_line = 0; act_line = 0; pend_ovf = 0; act_ovf = 0;
    endtask

    // first four qualifying entries in index order, among the first nv visited
    task automatic scan_model(input int l, input int nv);
        int py;
        pend_idx.delete();
        pend_ovf  = 0;
        pend_snap = desc;
        pend_line = l;
        for (int e = 0; e < nv; e++) begin
            py = int'(desc[e][15:6]);
            if (desc[e][31] && l >= py && l < py + SZ) begin
                if (pend_idx.size() < 4) pend_idx.push_back(e);
                else                     pend_ovf = 1;
            end
        end
    endtask

    function automatic pexp_t model_pix(input int h, input bit d);
        pexp_t       r;
        logic [31:0] e;
        int          px, py;
        r.de = d; r.hit = 0; r.idx = 0; r.ra = '0;
        if (d) begin
            foreach (act_idx[k]) begin
                e  = act_snap[act_idx[k]];
                px = int'(e[25:16]);
                py = int'(e[15:6]);
                if (!r.hit && h >= px && h < px + SZ) begin
                    r.hit = 1;
                    r.idx = act_idx[k];
                    r.ra  = {e[5:3], 5'(act_line - py), e[2:0], 5'(h - px)};
                end
            end
        end
        return r;
    endfunction

    task automatic wr(input int a, input logic [31:0] v);
        addr = 3'(a); dina = v; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        desc[a] = v;
    endtask

    task automatic clr();
        for (int a = 0; a < 8; a++) wr(a, 32'h0);
    endtask

    task automatic line_pulse(input int l);
        line_start = 1'b1; next_line = 10'(l);
        @(negedge clk);
        line_start = 1'b0;
        act_idx = pend_idx; act_snap = pend_snap; act_line = pend_line; act_ovf = pend_ovf;
        scan_model(l, 8);
        chk("overflow", 32'(overflow), 32'(act_ovf));
        chk("busy_start", 32'(scan_busy), 32'd1);
    endtask

    task automatic wait_scan();
        int n = 0;
        repeat (10) begin
            if (scan_busy) n++;
            @(negedge clk);
        end
        chk("busy_len", n, 8);
    endtask

    task automatic do_line(input int l);
        line_pulse(l);
        wait_scan();
    endtask

    task automatic px_step(input int h, input bit d);
        pexp_t e;
        if (pq.size() == 2) begin
            e = pq.pop_front();
            chk("pix_de", 32'(pix_de), 32'(e.de));
            chk("pix_hit", 32'(pix_hit), 32'(e.hit));
            chk("pix_idx", 32'(pix_idx), 32'(e.idx));
            chk("rom_addr", 32'(rom_addr), 32'(e.ra));
        end
        h_cnt = 10'(h); de = d;
        pq.push_back(model_pix(h, d));
        @(negedge clk);
    endtask

    task automatic px_flush();
        px_step(0, 0);
        px_step(0, 0);
        pq.delete();
    endtask

    initial begin
        int l, base, y, x;
        int hs1[5] = '{85, 79, 112, 111, 80};
        int hs2[8] = '{5, 0, 31, 32, 1000, 1023, 999, 5};
        int hs3[5] = '{200, 199, 231, 232, 215};

        repeat (2) @(negedge clk);
        chk("rst_pix_de", 32'(pix_de), 0);
        chk("rst_pix_hit", 32'(pix_hit), 0);
        chk("rst_pix_idx", 32'(pix_idx), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_busy", 32'(scan_busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        model_reset();

        // single sprite, known answers
        wr(0, mk(1, 80, 400, 0, 2));
        do_line(400);
        do_line(401);
        foreach (hs1[i]) px_step(hs1[i], 1);
        px_flush();
        h_cnt = 10'd85; de = 1'b1;
        repeat (2) @(negedge clk);
        chk("kat85_hit", 32'(pix_hit), 1);
        chk("kat85_idx", 32'(pix_idx), 0);
        chk("kat85_addr", 32'(rom_addr), 32'h0045);
        h_cnt = 10'd111;
        repeat (2) @(negedge clk);
        chk("kat111_addr", 32'(rom_addr), 32'h005F);
        h_cnt = 10'd112;
        repeat (2) @(negedge clk);
        chk("kat112_hit", 32'(pix_hit), 0);
        de = 1'b0;
        repeat (2) @(negedge clk);

        // right-edge sprite must not wrap onto column 5
        clr();
        wr(2, mk(1, 1000, 0, 1, 1));
        wr(5, mk(1, 0, 0, 3, 4));
        do_line(0);
        do_line(0);
        foreach (hs2[i]) px_step(hs2[i], 1);
        px_flush();

        // five sprites on one line: fifth dropped, overflow flagged
        clr();
        for (int e = 0; e < 5; e++) wr(e, mk(1, 200, 100, e, e));
        do_line(100);
        do_line(100);
        chk("ovf_kat", 32'(overflow), 1);
        foreach (hs3[i]) px_step(hs3[i], 1);
        px_flush();
        do_line(500);
        do_line(500);
        chk("ovf_clear", 32'(overflow), 0);

        // disabled entry and de gating
        clr();
        wr(3, mk(0, 300, 50, 0, 0));
        wr(6, mk(1, 300, 50, 2, 2));
        do_line(50);
        do_line(51);
        px_step(310, 1); px_step(310, 0); px_step(305, 0); px_step(305, 1); px_step(340, 1);
        px_flush();
        wr(6, mk(0, 300, 50, 2, 2));
        do_line(50);
        do_line(50);
        px_step(310, 1); px_step(300, 1);
        px_flush();

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            l    = $urandom_range(0, 1023);
            base = $urandom_range(0, 990);
            for (int e = 0; e < 8; e++) begin
                y = l - int'($urandom_range(0, 40));
                if (y < 0) y = $urandom_range(0, 1023);
                x = clampc(base + int'($urandom_range(0, 40)));
                wr(e, mk($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 7), $urandom_range(0, 7)));
            end
            do_line(l);
            do_line($urandom_range(0, 1023));
            for (int i = 0; i < 30; i++)
                px_step(clampc(base - 10 + int'($urandom_range(0, 90))), $urandom_range(0, 7) != 0);
            px_flush();
        end

        // line_start 3 cycles into a scan: partial set swapped, scan restarts
        clr();
        wr(0, mk(1, 100, 200, 1, 1));
        wr(3, mk(1, 300, 200, 2, 2));
        do_line(200);
        line_pulse(200);
        repeat (2) @(negedge clk);
        scan_model(200, 2);
        line_pulse(201);
        wait_scan();
        px_step(105, 1); px_step(305, 1); px_step(131, 1);
        px_flush();
        do_line(201);
        px_step(105, 1); px_step(305, 1);
        px_flush();

        // reset mid-scan
        h_cnt = 10'd105; de = 1'b1;
        line_pulse(201);
        @(negedge clk);
        chk("pre_rst_hit", 32'(pix_hit), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(scan_busy), 0);
        chk("midrst_hit", 32'(pix_hit), 0);
        chk("midrst_de", 32'(pix_de), 0);
        chk("midrst_addr", 32'(rom_addr), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        reset = 1'b0; de = 1'b0;
        model_reset();
        @(negedge clk);
        do_line(201);
        do_line(201);
        px_step(105, 1); px_step(305, 1);
        px_flush();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
